// File: rtl/enigma_pkg.sv
// Shared Enigma types: letter encoding and the IR letter-queue read-FSM states.
// Build option: IR_QUEUE_GAP_EN adds the post-transmission GAP state.
package enigma_pkg;

    typedef logic [4:0] letter_t;

    localparam int unsigned LETTER_COUNT = 26;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
`ifdef IR_QUEUE_GAP_EN
        ,
        ST_GAP       = 3'd5
`endif
    } ir_queue_state_t;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// True dual-port, read-first, single-clock block RAM. "HIGH_PERFORMANCE" adds
// an output register stage (2-cycle read); "LOW_LATENCY" reads in 1 cycle.
// No reset: contents and output registers power up undefined.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int unsigned RAM_WIDTH       = 18,
    parameter int unsigned RAM_DEPTH       = 1024,
    parameter              RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    localparam int unsigned ADDR_W         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clka,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic [RAM_WIDTH-1:0] dinb,
    input  logic                 wea,
    input  logic                 web,
    input  logic                 ena,
    input  logic                 enb,
    input  logic                 regcea,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] douta,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_data_a;
    logic [RAM_WIDTH-1:0] r_data_b;

    // Both ports share one clock; reads return the word held before any same-cycle write.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) r_mem[addra] <= dina;
            r_data_a <= r_mem[addra];
        end
        if (enb) begin
            if (web) r_mem[addrb] <= dinb;
            r_data_b <= r_mem[addrb];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
        logic w_unused_regce;
        assign w_unused_regce = regcea ^ regceb;
        assign douta = r_data_a;
        assign doutb = r_data_b;
    end else begin : g_out_reg
        logic [RAM_WIDTH-1:0] r_dout_a;
        logic [RAM_WIDTH-1:0] r_dout_b;

        // Second pipeline stage of the read path.
        always_ff @(posedge clka) begin
            if (regcea) r_dout_a <= r_data_a;
            if (regceb) r_dout_b <= r_data_b;
        end

        assign douta = r_dout_a;
        assign doutb = r_dout_b;
    end

endmodule

// File: rtl/ir_letter_queue.sv
// Elastic letter queue between the Enigma encoder and the IR transmitter.
// Captures a letter on each rising edge of the encoder valid level, stores it
// in a circular RAM buffer, and hands letters to the transmitter one at a time,
// popping each only after its transmission has finished.
// Build option: IR_QUEUE_GAP_EN inserts a GAP_CYCLES idle guard after each send.
module ir_letter_queue
    import enigma_pkg::*;
#(
    parameter int unsigned  DEPTH      = 1000,
    parameter int unsigned  GAP_CYCLES = 100000,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             letter_valid_in,
    input  logic [4:0]       letter_in,
    input  logic             tx_busy_in,
    output logic             tx_valid_out,
    output logic [4:0]       tx_letter_out,
    output logic [CNT_W-1:0] count_out,
    output logic             empty_out,
    output logic             full_out,
    output logic             overflow_out
);

    localparam int unsigned      AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]    LAST_SLOT  = AW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic            r_valid_q;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic            r_overflow;
    ir_queue_state_t r_state;
    logic            r_fetch_wait;
    logic            r_tx_valid;
    letter_t         r_tx_letter;

    letter_t w_ram_dout;
    letter_t w_unused_douta;
    logic    w_write_evt;
    logic    w_wr_en;
    logic    w_pop;
    logic    w_empty;
    logic    w_full;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_COUNT);
    assign w_write_evt = letter_valid_in && !r_valid_q;
    assign w_wr_en     = w_write_evt && !w_full;
    assign w_pop       = (r_state == ST_WAIT_DONE) && !tx_busy_in;

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (5),
        .RAM_DEPTH       (DEPTH),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_ram (
        .clka   (clk_in),
        .addra  (r_wr_ptr),
        .addrb  (r_rd_ptr),
        .dina   (letter_in),
        .dinb   ('0),
        .wea    (w_wr_en),
        .web    (1'b0),
        .ena    (1'b1),
        .enb    (1'b1),
        .regcea (1'b1),
        .regceb (1'b1),
        .douta  (w_unused_douta),
        .doutb  (w_ram_dout)
    );

    // Write side: edge-detect the encoder valid, store or flag overflow.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid_q  <= 1'b0;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_valid_q <= letter_valid_in;
            if (w_wr_en) r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + AW'(1);
            if (w_write_evt && w_full) r_overflow <= 1'b1;
        end
    end

    // Occupancy and read pointer; a simultaneous write and pop cancel in the count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IR_QUEUE_GAP_EN
    localparam int unsigned       GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [GAP_W-1:0] r_gap_cnt;

    // Gap timer: counts cycles spent in GAP, cleared everywhere else.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                r_gap_cnt <= '0;
        else if (r_state == ST_GAP)   r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        else                          r_gap_cnt <= '0;
    end
`else
    logic [31:0] w_unused_gap;
    assign w_unused_gap = GAP_CYCLES;
`endif

    // Read FSM: fetch head letter, pulse start, then track busy high and low.
    // The start pulse and letter are registered on the FETCH->SEND transition
    // so both are visible exactly while the FSM sits in SEND.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_IDLE;
            r_fetch_wait <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_letter  <= '0;
        end else begin
            r_tx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_fetch_wait <= 1'b0;
                    if (!w_empty) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (r_fetch_wait) begin
                        r_tx_letter <= w_ram_dout;
                        r_tx_valid  <= 1'b1;
                        r_state     <= ST_SEND;
                    end else begin
                        r_fetch_wait <= 1'b1;
                    end
                end
                ST_SEND:      r_state <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: if (tx_busy_in) r_state <= ST_WAIT_DONE;
`ifdef IR_QUEUE_GAP_EN
                ST_WAIT_DONE: if (!tx_busy_in) r_state <= ST_GAP;
                ST_GAP:       if (r_gap_cnt == GAP_LAST) r_state <= ST_IDLE;
`else
                ST_WAIT_DONE: if (!tx_busy_in) r_state <= ST_IDLE;
`endif
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_valid_out  = r_tx_valid;
    assign tx_letter_out = r_tx_letter;
    assign count_out     = r_count;
    assign empty_out     = w_empty;
    assign full_out      = w_full;
    assign overflow_out  = r_overflow;

endmodule
